// File: rtl/window_feeder_if.sv
// Handshake bundle between the pixel FIFOs, the window shift chain and feeder.
// Carries the optional border flag when BORDER_FLAG_EN is defined.
interface window_feeder_if #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic          start;
  logic          in_empty;
  logic [7:0]    in_dout;
  logic          in_rd_en;
  logic          out_full;
  logic          shift_en;
  logic [7:0]    pixel_out;
  logic          win_valid;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          busy;
  logic          frame_done;
`ifdef BORDER_FLAG_EN
  logic          border;

  modport master (
    output start, in_empty, in_dout, out_full,
    input  in_rd_en, shift_en, pixel_out,
    input  win_valid, win_col, win_row,
    input  busy, frame_done, border
  );

  modport slave (
    input  start, in_empty, in_dout, out_full,
    output in_rd_en, shift_en, pixel_out,
    output win_valid, win_col, win_row,
    output busy, frame_done, border
  );
`else
  modport master (
    output start, in_empty, in_dout, out_full,
    input  in_rd_en, shift_en, pixel_out,
    input  win_valid, win_col, win_row,
    input  busy, frame_done
  );

  modport slave (
    input  start, in_empty, in_dout, out_full,
    output in_rd_en, shift_en, pixel_out,
    output win_valid, win_col, win_row,
    output busy, frame_done
  );
`endif
endinterface

// File: rtl/window_feeder.sv
// Feeds FIFO pixels into the 3x3 window chain and flags complete windows.
// Optional BORDER_FLAG_EN: window strobe on every pixel plus a border flag.
module window_feeder #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic clock,
  input  logic reset,
  window_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;
`ifdef BORDER_FLAG_EN
  logic          border_q, border_d;
`endif
  logic          fire;

  // no pop may happen in a cycle where reset is held
  assign fire = reset && (state_q == STREAM)
             && !bus.in_empty && !bus.out_full;

  assign bus.in_rd_en   = fire;
  assign bus.shift_en   = fire;
  assign bus.pixel_out  = bus.in_dout;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;
  assign bus.busy       = (state_q == STREAM);
  assign bus.frame_done = (state_q == DONE);
`ifdef BORDER_FLAG_EN
  assign bus.border     = border_q;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = 1'b0;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
`ifdef BORDER_FLAG_EN
    border_d    = border_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          col_d   = '0;
          row_d   = '0;
        end
      end
      STREAM: begin
        if (fire) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef BORDER_FLAG_EN
    if (fire) begin
      win_valid_d = 1'b1;
      win_col_d   = col_q;
      win_row_d   = row_q;
      border_d    = (row_q < RW'(2)) || (col_q < CW'(2));
    end
`else
    if (fire && row_q >= RW'(2) && col_q >= CW'(2)) begin
      win_valid_d = 1'b1;
      win_col_d   = col_q;
      win_row_d   = row_q;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
`ifdef BORDER_FLAG_EN
      border_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
`ifdef BORDER_FLAG_EN
      border_q    <= border_d;
`endif
    end
  end
endmodule

// File: tb/tb_window_feeder.sv
// Randomized bench for window_feeder with a raster-index reference model.
// Build with BORDER_FLAG_EN to cover the border-flag variant.
module tb_window_feeder;
  localparam int W = 4;
  localparam int H = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  window_feeder_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  window_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic       hold_empty;
  logic [7:0] fifo [0:31];
  int         head, tail;

  always_comb begin
    bus.in_empty = hold_empty || (head >= tail);
    bus.in_dout  = (head < tail) ? fifo[head[4:0]] : 8'h00;
  end

  // model: frame state (0 idle, 1 stream, 2 done) and pixel index in frame
  int mstate, mn;
  int exp_wv, exp_wc, exp_wr, exp_bd;
  bit armed = 1'b0;

  int obs_fire, obs_wv, obs_fd, obs_bd0;
  int obs_wc [$];
  int obs_wr [$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit fire_exp();
    return reset && (mstate == 1)
        && !bus.in_empty && !bus.out_full;
  endfunction

  always @(posedge clock) begin : model
    bit f;
    int r, c;
    f = fire_exp();
    if (!reset) begin
      mstate = 0; mn = 0;
      exp_wv = 0; exp_wc = 0; exp_wr = 0; exp_bd = 0;
      armed = 1'b1;
    end else begin
      exp_wv = 0;
      if (f) begin
        r = mn / W;
        c = mn % W;
`ifdef BORDER_FLAG_EN
        exp_wv = 1; exp_wc = c; exp_wr = r;
        exp_bd = (r < 2 || c < 2) ? 1 : 0;
`else
        if (r >= 2 && c >= 2) begin
          exp_wv = 1; exp_wc = c; exp_wr = r;
        end
`endif
        mn++;
        head++;
        if (mn == W * H) begin
          mstate = 2;
          mn = 0;
        end
      end else if (mstate == 0 && bus.start) begin
        mstate = 1;
        mn = 0;
      end else if (mstate == 2) begin
        mstate = 0;
      end
    end
  end

  always @(negedge clock) begin : compare
    bit f;
    if (armed) begin
      f = fire_exp();
      chk("shift_en", int'(bus.shift_en), int'(f));
      chk("in_rd_en", int'(bus.in_rd_en), int'(f));
      chk("pixel_pass", int'(bus.pixel_out), int'(bus.in_dout));
      if (f) chk("pixel_seq", int'(bus.pixel_out), mn + 1);
      chk("busy", int'(bus.busy), (mstate == 1) ? 1 : 0);
      chk("frame_done", int'(bus.frame_done), (mstate == 2) ? 1 : 0);
      chk("win_valid", int'(bus.win_valid), exp_wv);
      chk("win_col", int'(bus.win_col), exp_wc);
      chk("win_row", int'(bus.win_row), exp_wr);
`ifdef BORDER_FLAG_EN
      chk("border", int'(bus.border), exp_bd);
`endif
      if (bus.shift_en) obs_fire++;
      if (bus.frame_done) obs_fd++;
      if (bus.win_valid) begin
        obs_wv++;
`ifdef BORDER_FLAG_EN
        if (!bus.border) begin
          obs_bd0++;
          obs_wc.push_back(int'(bus.win_col));
          obs_wr.push_back(int'(bus.win_row));
        end
`else
        obs_wc.push_back(int'(bus.win_col));
        obs_wr.push_back(int'(bus.win_row));
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic reload();
    head = 0;
    tail = 0;
    for (int i = 0; i < W * H; i++) fifo[i] = 8'(i + 1);
    tail = W * H;
  endtask

  task automatic clear_obs();
    obs_fire = 0; obs_wv = 0; obs_fd = 0; obs_bd0 = 0;
    obs_wc.delete();
    obs_wr.delete();
  endtask

  task automatic run_frame(int mode);
    int n_full;
    int cnt;
    n_full = 0;
    cnt = 0;
    clear_obs();
    reload();
    bus.start = 1'b1;
    hold_empty = 1'b0;
    bus.out_full = 1'b0;
    cyc();
    bus.start = 1'b0;
    while (obs_fd == 0 && cnt < 400) begin
      case (mode)
        1: hold_empty = ~hold_empty;
        2: begin
          if (mn == 5 && n_full == 0) begin
            bus.out_full = 1'b1;
            n_full = 1;
          end else if (n_full > 0 && n_full < 5) begin
            n_full++;
          end else if (n_full == 5) begin
            bus.out_full = 1'b0;
            n_full = 6;
          end
        end
        3: begin
          hold_empty = ($urandom_range(0, 2) == 0);
          bus.out_full = ($urandom_range(0, 2) == 0);
        end
        4: bus.start = (cnt == 3);
        default: ;
      endcase
      cyc();
      cnt++;
    end
    bus.start = 1'b0;
    hold_empty = 1'b0;
    bus.out_full = 1'b0;
    chk("frame_in_budget", (cnt < 400) ? 1 : 0, 1);
    repeat (4) cyc();
    chk("fire_count", obs_fire, 12);
    chk("frame_done_count", obs_fd, 1);
`ifdef BORDER_FLAG_EN
    chk("win_valid_count", obs_wv, 12);
    chk("border0_count", obs_bd0, 2);
`else
    chk("win_valid_count", obs_wv, 2);
`endif
    chk("interior_windows", obs_wc.size(), 2);
    if (obs_wc.size() >= 2) begin
      chk("win0_row", obs_wr[0], 2);
      chk("win0_col", obs_wc[0], 2);
      chk("win1_row", obs_wr[1], 2);
      chk("win1_col", obs_wc[1], 3);
    end
  endtask

  task automatic reset_mid_frame();
    int cnt;
    cnt = 0;
    reload();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    while (mn != 7 && cnt < 100) begin
      cyc();
      cnt++;
    end
    chk("reach_pixel7", (cnt < 100) ? 1 : 0, 1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_wv", int'(bus.win_valid), 0);
    chk("mid_rst_wcol", int'(bus.win_col), 0);
    chk("mid_rst_wrow", int'(bus.win_row), 0);
    chk("mid_rst_fd", int'(bus.frame_done), 0);
    chk("mid_rst_rd", int'(bus.in_rd_en), 0);
    run_frame(0);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.out_full = 1'b0;
    hold_empty = 1'b0;
    head = 0;
    tail = 0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_win_valid", int'(bus.win_valid), 0);
    chk("rst_win_col", int'(bus.win_col), 0);
    chk("rst_win_row", int'(bus.win_row), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    for (int k = 0; k < 4; k++) run_frame(3);
    reset_mid_frame();
    run_frame(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
